// File: rtl/viewport_scanner_tiled.sv
`default_nettype none
// ============================================================================
// Module   : viewport_scanner_tiled
// Purpose  : Fragment coordinate generator with valid/ready handshake and
//            raster or tiled scan order. Optional frame counter under
//            VIEWPORT_SCANNER_FRAME_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module viewport_scanner_tiled #(
    parameter int H_DISP  = 1280,
    parameter int V_DISP  = 720,
    parameter int COORD_W = 20,
    parameter int TILE_W  = 16,
    parameter int TILE_H  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               continuous,
    input  logic               tiled_mode,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] fragment_uv_x,
    output logic [COORD_W-1:0] fragment_uv_y,
    output logic               sof,
    output logic               eol,
    output logic               eot,
    output logic               eof
`ifdef VIEWPORT_SCANNER_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int CW = COORD_W + 1;
    localparam logic [CW-1:0] c_h_disp = CW'(H_DISP);
    localparam logic [CW-1:0] c_v_disp = CW'(V_DISP);
    localparam logic [CW-1:0] c_tile_w = CW'(TILE_W);
    localparam logic [CW-1:0] c_tile_h = CW'(TILE_H);
    localparam logic [CW-1:0] c_one    = CW'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    // Span of the current tile along one axis; raster mode is one viewport-sized tile.
    function automatic logic [CW-1:0] f_span(input logic tiled, input logic [CW-1:0] org,
                                             input logic [CW-1:0] full, input logic [CW-1:0] tile);
        logic [CW-1:0] rem;
        rem = full - org;
        if (!tiled) return full;
        return (rem < tile) ? rem : tile;
    endfunction

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [CW-1:0]       tx0_q, tx0_d, ty0_q, ty0_d;
    logic [CW-1:0]       lx_q, lx_d, ly_q, ly_d;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic                out_valid_q, out_valid_d, busy_q, busy_d;
    logic                sof_q, sof_d, eol_q, eol_d, eot_q, eot_d, eof_q, eof_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic [CW-1:0]       w_tw, w_th, w_tw_n, w_th_n;
    logic                w_live, w_row_end, w_tile_end, w_last_tile, w_clear;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        tx0_d       = tx0_q;
        ty0_d       = ty0_q;
        lx_d        = lx_q;
        ly_d        = ly_q;
        frame_cnt_d = frame_cnt_q;
        w_clear     = 1'b0;

        w_tw = f_span(mode_q, tx0_q, c_h_disp, c_tile_w);
        w_th = f_span(mode_q, ty0_q, c_v_disp, c_tile_h);

        case (state_q)
            S_IDLE: begin
                w_clear = 1'b1;
                if (start) begin
                    state_d = S_SCAN;
                    mode_d  = tiled_mode;
                end
            end
            S_SCAN: begin
                if (out_ready) begin
                    if (eof_q) begin
                        w_clear     = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        if (continuous) mode_d = tiled_mode;
                        else            state_d = S_IDLE;
                    end else if (lx_q != w_tw - c_one) begin
                        lx_d = lx_q + c_one;
                    end else begin
                        lx_d = '0;
                        if (ly_q != w_th - c_one) begin
                            ly_d = ly_q + c_one;
                        end else begin
                            ly_d = '0;
                            if (tx0_q + c_tile_w < c_h_disp) begin
                                tx0_d = tx0_q + c_tile_w;
                            end else begin
                                tx0_d = '0;
                                ty0_d = ty0_q + c_tile_h;
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_clear) begin
            tx0_d = '0;
            ty0_d = '0;
            lx_d  = '0;
            ly_d  = '0;
        end

        // Flags describe the pixel that will be presented next cycle.
        w_tw_n      = f_span(mode_d, tx0_d, c_h_disp, c_tile_w);
        w_th_n      = f_span(mode_d, ty0_d, c_v_disp, c_tile_h);
        w_row_end   = (lx_d == w_tw_n - c_one);
        w_tile_end  = w_row_end && (ly_d == w_th_n - c_one);
        w_last_tile = (tx0_d + c_tile_w >= c_h_disp) && (ty0_d + c_tile_h >= c_v_disp);
        w_live      = (state_d == S_SCAN);

        out_valid_d = w_live;
        busy_d      = w_live;
        x_d         = w_live ? COORD_W'(tx0_d + lx_d) : '0;
        y_d         = w_live ? COORD_W'(ty0_d + ly_d) : '0;
        sof_d       = w_live && (tx0_d == '0) && (ty0_d == '0) && (lx_d == '0) && (ly_d == '0);
        eol_d       = w_live && w_row_end;
        eot_d       = w_live && mode_d && w_tile_end;
        eof_d       = w_live && w_tile_end && (!mode_d || w_last_tile);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            tx0_q       <= '0;
            ty0_q       <= '0;
            lx_q        <= '0;
            ly_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eot_q       <= 1'b0;
            eof_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            tx0_q       <= tx0_d;
            ty0_q       <= ty0_d;
            lx_q        <= lx_d;
            ly_q        <= ly_d;
            x_q         <= x_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            eot_q       <= eot_d;
            eof_q       <= eof_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign busy          = busy_q;
    assign out_valid     = out_valid_q;
    assign fragment_uv_x = x_q;
    assign fragment_uv_y = y_q;
    assign sof           = sof_q;
    assign eol           = eol_q;
    assign eot           = eot_q;
    assign eof           = eof_q;

`ifdef VIEWPORT_SCANNER_FRAME_CNT_EN
    assign frame_cnt = frame_cnt_q;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = ^frame_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_viewport_scanner_tiled.sv
`default_nettype none
// ============================================================================
// Module   : tb_viewport_scanner_tiled
// Purpose  : Scoreboard bench for viewport_scanner_tiled (5x3 with 2x2 tiles,
//            plus a 1x1 viewport instance).
// Revision : 1.0  initial release
// ============================================================================
module tb_viewport_scanner_tiled;

    localparam int TB_CW = 20;

    typedef struct packed {
        logic [TB_CW-1:0] x;
        logic [TB_CW-1:0] y;
        logic             sof;
        logic             eol;
        logic             eot;
        logic             eof;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, continuous = 1'b0, tiled_mode = 1'b0, out_ready = 1'b1;
    logic busy, out_valid, sof, eol, eot, eof;
    logic [TB_CW-1:0] x, y;

    logic start1 = 1'b0, mode1 = 1'b0;
    logic busy1, v1, sof1, eol1, eot1, eof1;
    logic [TB_CW-1:0] x1, y1;

`ifdef VIEWPORT_SCANNER_FRAME_CNT_EN
    logic [15:0] frame_cnt, frame_cnt1;
`endif

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    viewport_scanner_tiled #(.H_DISP(5), .V_DISP(3), .COORD_W(TB_CW), .TILE_W(2), .TILE_H(2)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .tiled_mode(tiled_mode),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .fragment_uv_x(x), .fragment_uv_y(y), .sof(sof), .eol(eol), .eot(eot), .eof(eof)
`ifdef VIEWPORT_SCANNER_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    viewport_scanner_tiled #(.H_DISP(1), .V_DISP(1), .COORD_W(TB_CW), .TILE_W(2), .TILE_H(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .continuous(1'b0), .tiled_mode(mode1),
        .busy(busy1), .out_valid(v1), .out_ready(1'b1),
        .fragment_uv_x(x1), .fragment_uv_y(y1), .sof(sof1), .eol(eol1), .eot(eot1), .eof(eof1)
`ifdef VIEWPORT_SCANNER_FRAME_CNT_EN
        , .frame_cnt(frame_cnt1)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input int px, input int py, input bit s, input bit l, input bit t, input bit f);
        beat_t b;
        b.x = TB_CW'(px); b.y = TB_CW'(py);
        b.sof = s; b.eol = l; b.eot = t; b.eof = f;
        exp_q.push_back(b);
    endtask

    task automatic push_raster(input int n);
        for (int i = 0; i < n; i++)
            push(i % 5, i / 5, i == 0, (i % 5) == 4, 1'b0, i == 14);
    endtask

    task automatic push_tiled();
        int tx[15]  = '{0,1,0,1,2,3,2,3,4,4,0,1,2,3,4};
        int ty[15]  = '{0,0,1,1,0,0,1,1,0,1,2,2,2,2,2};
        int el[15]  = '{0,1,0,1,0,1,0,1,1,1,0,1,0,1,1};
        int et[15]  = '{0,0,0,1,0,0,0,1,0,1,0,1,0,1,1};
        for (int i = 0; i < 15; i++)
            push(tx[i], ty[i], i == 0, el[i] != 0, et[i] != 0, i == 14);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic drain(input int budget, input bit rnd);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        out_ready = 1'b1;
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Compare the presented pixel every valid cycle; retire it only on handshake.
    always @(negedge clk) begin
        beat_t a, e;
        if (out_valid === 1'b1) begin
            a.x = x; a.y = y; a.sof = sof; a.eol = eol; a.eot = eot; a.eof = eof;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: actual x=%0d y=%0d required no beat", x, y);
            end else begin
                e = exp_q[0];
                if (a !== e) begin
                    errors++;
                    $display("FAIL beat: actual x=%0d y=%0d sof/eol/eot/eof=%b%b%b%b required x=%0d y=%0d sof/eol/eot/eof=%b%b%b%b",
                             a.x, a.y, a.sof, a.eol, a.eot, a.eof, e.x, e.y, e.sof, e.eol, e.eot, e.eof);
                end
                if (out_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        logic found;
`ifdef VIEWPORT_SCANNER_FRAME_CNT_EN
        logic [15:0] fc0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_xy", 64'({x, y}), 64'd0);
        chk("reset_flags", 64'({sof, eol, eot, eof}), 64'd0);
`ifdef VIEWPORT_SCANNER_FRAME_CNT_EN
        chk("reset_frame_cnt", 64'(frame_cnt), 64'd0);
`endif

        // Raster frame; a start pulse and mode change mid-frame must be ignored.
        tiled_mode = 1'b0;
        push_raster(15);
        pulse_start();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_in_scan", 64'(busy), 64'd1);
        start = 1'b1; tiled_mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; tiled_mode = 1'b0;
        drain(100, 1'b0);
        chk("raster_end_valid", 64'(out_valid), 64'd0);
        chk("raster_end_busy", 64'(busy), 64'd0);

        // Tiled frame, no backpressure.
        tiled_mode = 1'b1;
        push_tiled();
        pulse_start();
        drain(100, 1'b0);
        chk("tiled_end_valid", 64'(out_valid), 64'd0);

        // Tiled frame with random backpressure.
        push_tiled();
        pulse_start();
        drain(400, 1'b1);
        chk("bp_end_valid", 64'(out_valid), 64'd0);
        chk("bp_end_busy", 64'(busy), 64'd0);

        // Two back-to-back frames: raster then tiled.
`ifdef VIEWPORT_SCANNER_FRAME_CNT_EN
        fc0 = frame_cnt;
`endif
        tiled_mode = 1'b0;
        continuous = 1'b1;
        push_raster(15);
        push_tiled();
        pulse_start();
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            if (out_valid === 1'b1 && eof === 1'b1) found = 1'b1;
            n++;
        end
        chk("cont_eof_seen", 64'(found), 64'd1);
        tiled_mode = 1'b1;
        @(posedge clk); #1;
        continuous = 1'b0;
        chk("cont_no_bubble", 64'({out_valid, sof}), 64'b11);
        chk("cont_origin", 64'({x, y}), 64'd0);
        drain(100, 1'b0);
        chk("cont_end_valid", 64'(out_valid), 64'd0);
`ifdef VIEWPORT_SCANNER_FRAME_CNT_EN
        chk("cont_frame_cnt", 64'(frame_cnt), 64'(16'(fc0 + 16'd2)));
`endif

        // Reset while (3,1) is presented in raster mode.
        tiled_mode = 1'b0;
        push_raster(9);
        pulse_start();
        found = 1'b0;
        n = 0;
        while (!found && n < 60) begin
            if (out_valid === 1'b1 && x == 3 && y == 1) found = 1'b1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("rst_target_seen", 64'(found), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_xy", 64'({x, y}), 64'd0);
        chk("midrst_flags", 64'({sof, eol, eot, eof}), 64'd0);
`ifdef VIEWPORT_SCANNER_FRAME_CNT_EN
        chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
        rst = 1'b0;
        chk("midrst_beats_before", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        chk("after_rst_idle", 64'(out_valid), 64'd0);

        // 1x1 viewport, tiled then raster.
        mode1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        chk("one_tiled_beat", 64'({v1, x1, y1}), {23'd0, 1'b1, 40'd0});
        chk("one_tiled_flags", 64'({sof1, eol1, eot1, eof1}), 64'b1111);
        @(posedge clk); #1;
        chk("one_tiled_done", 64'({v1, busy1}), 64'd0);
        mode1 = 1'b0;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        chk("one_raster_beat", 64'({v1, x1, y1}), {23'd0, 1'b1, 40'd0});
        chk("one_raster_flags", 64'({sof1, eol1, eot1, eof1}), 64'b1101);
        @(posedge clk); #1;
        chk("one_raster_done", 64'({v1, busy1}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/viewport_scanner_tiled.md
Name: viewport_scanner_tiled

Overview:
- Generates the fragment coordinate stream for the pixel pipeline. It is the successor of the plain free-running raster counter.
- Adds a valid/ready handshake with backpressure and start/continuous frame control.
- Adds a runtime-selectable scan order: raster, or tiled with clipped partial edge tiles.
- Adds per-pixel frame, line and tile markers.
- Sits at the head of the fragment pipeline and feeds the shader/texture stages.

Parameters:
- H_DISP, 1280, viewport width in pixels (>=1).
- V_DISP, 720, viewport height in pixels (>=1).
- COORD_W, 20, width of coordinate outputs; must hold H_DISP-1 and V_DISP-1.
- TILE_W, 16, tile width in pixels (>=1, need not divide H_DISP).
- TILE_H, 16, tile height in pixels (>=1, need not divide V_DISP).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- continuous  in  1  sampled at end of frame; 1 = restart immediately
- tiled_mode  in  1  scan order (0 raster, 1 tiled); latched at each frame start
- busy  out  1  high in SCAN
- out_valid  out  1  coordinate valid
- out_ready  in  1  downstream accepts
- fragment_uv_x  out  COORD_W  pixel x
- fragment_uv_y  out  COORD_W  pixel y
- sof  out  1  first pixel of frame
- eol  out  1  last pixel of a scan row (raster: x==H_DISP-1; tiled: last pixel of a tile row)
- eot  out  1  last pixel of a tile (tiled only; 0 in raster)
- eof  out  1  last pixel of frame

Behaviour:
- Reset (synchronous, clocked on clk) forces:
  - state IDLE
  - busy=0, out_valid=0
  - x=y=0
  - sof=eol=eot=eof=0
  - latched mode=raster
- States: IDLE and SCAN.
- IDLE:
  - out_valid=0.
  - start=1 latches tiled_mode and loads the origin. All tile and local counters are cleared.
  - The next cycle is SCAN with out_valid=1, x=0, y=0, sof=1.
- SCAN:
  - out_valid=1 continuously.
  - Outputs and flags hold stable while out_ready=0 (AXI-stream style; no combinational path from out_ready to outputs).
  - Advance happens on handshake (out_valid & out_ready) only.
- Raster advance:
  - x increments.
  - At x==H_DISP-1, x wraps to 0 and y increments.
- Tiled advance:
  - Internal counters: tile origin tx0/ty0 and local lx/ly.
  - Output coordinates: x=tx0+lx, y=ty0+ly.
  - Effective tile width tw = min(TILE_W, H_DISP-tx0). Effective tile height th = min(TILE_H, V_DISP-ty0).
  - Within a tile: lx steps to tw-1, then wraps to 0 and ly increments.
  - At the end of a tile, if tx0+TILE_W < H_DISP: tx0 += TILE_W.
  - Otherwise tx0=0 and ty0 += TILE_H.
  - Tile order is row-major; pixel order inside a tile is row-major.
- Flags are registered alongside coordinates and describe the currently presented pixel. sof/eol/eot/eof may coincide (e.g. 1x1 viewport: all four high).
- End of frame (handshake with eof=1):
  - If continuous=1: re-latch tiled_mode. The next cycle presents (0,0) with sof=1 and out_valid stays high (no bubble).
  - Else: go to IDLE, out_valid=0.
  - start is ignored outside IDLE.
- Pixels per frame = H_DISP*V_DISP in both modes. Each coordinate appears exactly once.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. Any partial frame is discarded.
- Counter arithmetic uses COORD_W+1 bits internally so tx0+TILE_W cannot overflow.

Optional Feature:
- Macro: VIEWPORT_SCANNER_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt (16 bits, reset 0).
  - frame_cnt increments by 1 on each eof handshake and wraps at 0xFFFF->0.
  - It is not cleared by start.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Params H_DISP=5, V_DISP=3, TILE 2x2. Raster mode, out_ready=1, start pulse:
  - 15 beats (0,0)..(4,0),(0,1)..(4,2).
  - eol on x=4 beats; sof on beat 0; eof on beat 14.
  - Then out_valid=0, busy=0.
- Same params, tiled, out_ready=1. Required 15-beat order:
  - (0,0)(1,0)(0,1)(1,1)
  - (2,0)(3,0)(2,1)(3,1)
  - (4,0)(4,1)
  - (0,2)(1,2)
  - (2,2)(3,2)
  - (4,2)
  - eot on beats 3,7,9,11,13,14; eof on beat 14.
- Backpressure: random out_ready (~50%) in tiled mode:
  - Coordinates and flags hold while out_ready=0.
  - Accepted sequence is identical to the previous scenario; no duplicates or skips.
- continuous=1, two frames, alternating tiled_mode at the eof beat:
  - Beat after eof is (0,0) with sof=1 and no idle cycle.
  - Second frame uses the new order.
  - With the macro defined, frame_cnt=2.
- Reset asserted mid-frame at (3,1):
  - Next cycle out_valid=0, coordinates 0, flags 0, busy=0.
  - start while busy has no effect.
- Edge params H_DISP=1, V_DISP=1:
  - Single beat (0,0) with sof=eol=eot=eof=1 in tiled mode.
  - Single beat (0,0) with sof=eol=eof=1 and eot=0 in raster mode.
